// File: rtl/axis_packet_generator.sv
// axis_packet_generator
// Accepts 16-bit packet-length descriptors on an AXI-Stream input and emits one
// AXI-Stream packet per descriptor. Lane k of each beat carries
// (seed + byte_off + k) mod 256, and the seed advances once per completed packet.
// Optional feature macro: PKT_GEN_LEN_HEADER_EN. When it is defined, the first
// beat carries the packet length little-endian in lanes 0..1.
// All outputs are registered. Reset is asynchronous and active-high.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | ready for a descriptor; len=0 is consumed and dropped
//   SEND  | presenting beats; the descriptor input is ignored until done

module axis_packet_generator #(
   parameter int         DW        = 128,
   parameter logic [7:0] SEED_INIT = 8'h00
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [15:0]     axis_len_tdata,
   input  logic            axis_len_tvalid,
   output logic            axis_len_tready,
   output logic [DW-1:0]   axis_out_tdata,
   output logic [DW/8-1:0] axis_out_tkeep,
   output logic            axis_out_tlast,
   output logic            axis_out_tvalid,
   input  logic            axis_out_tready,
   output logic [31:0]     pkt_sent_count
);

   localparam int BPB = DW / 8;

   typedef enum logic {IDLE, SEND} state_t;

   state_t          state;
   logic [15:0]     len_q;
   logic [15:0]     beats_left;
   logic [15:0]     byte_off;
   logic [7:0]      seed;

   logic [16:0]     len_round;
   logic [15:0]     beats_init;
   logic [15:0]     b_len;
   logic [15:0]     b_off;
   logic [15:0]     b_left;
   logic [15:0]     b_rem;
   logic [7:0]      lane;
   logic [DW-1:0]   b_data;
   logic [BPB-1:0]  b_keep;

   // Beat count for an incoming descriptor. The sum is widened to 17 bits so
   // that len=65535 cannot overflow before the divide.
   always_comb begin
      len_round  = {1'b0, axis_len_tdata} + 17'(BPB - 1);
      beats_init = 16'(len_round / 17'(BPB));
   end

   // Contents of the next beat to load: in IDLE it is the first beat of the
   // incoming descriptor, in SEND it is the beat after the one on the bus.
   always_comb begin
      lane   = 8'h00;
      b_data = '0;
      b_keep = '0;
      if (state == IDLE) begin
         b_len  = axis_len_tdata;
         b_off  = 16'd0;
         b_left = beats_init;
      end else begin
         b_len  = len_q;
         b_off  = byte_off + 16'(BPB);
         b_left = beats_left - 16'd1;
      end
      b_rem = b_len % 16'(BPB);
      for (int k = 0; k < BPB; k++) begin
         b_keep[k] = (b_left != 16'd1) || (b_rem == 16'd0) || (16'(k) < b_rem);
         lane      = seed + b_off[7:0] + 8'(k);
`ifdef PKT_GEN_LEN_HEADER_EN
         if (state == IDLE && k == 0) lane = b_len[7:0];
         if (state == IDLE && k == 1) lane = b_len[15:8];
`endif
         b_data[8*k +: 8] = b_keep[k] ? lane : 8'h00;
      end
   end

   // Descriptor/beat sequencing. Output registers only change on a handshake,
   // so they hold steady across downstream stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         len_q           <= '0;
         beats_left      <= '0;
         byte_off        <= '0;
         seed            <= SEED_INIT;
         pkt_sent_count  <= '0;
         axis_len_tready <= 1'b0;
         axis_out_tdata  <= '0;
         axis_out_tkeep  <= '0;
         axis_out_tlast  <= 1'b0;
         axis_out_tvalid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               axis_len_tready <= 1'b1;
               if (axis_len_tready && axis_len_tvalid && axis_len_tdata != 16'd0) begin
                  len_q           <= axis_len_tdata;
                  beats_left      <= beats_init;
                  byte_off        <= 16'd0;
                  axis_out_tdata  <= b_data;
                  axis_out_tkeep  <= b_keep;
                  axis_out_tlast  <= (beats_init == 16'd1);
                  axis_out_tvalid <= 1'b1;
                  axis_len_tready <= 1'b0;
                  state           <= SEND;
               end
            end
            SEND: begin
               if (axis_out_tready) begin
                  if (beats_left == 16'd1) begin
                     pkt_sent_count  <= pkt_sent_count + 32'd1;
                     seed            <= seed + 8'd1;
                     axis_out_tdata  <= '0;
                     axis_out_tkeep  <= '0;
                     axis_out_tlast  <= 1'b0;
                     axis_out_tvalid <= 1'b0;
                     axis_len_tready <= 1'b1;
                     state           <= IDLE;
                  end else begin
                     beats_left     <= b_left;
                     byte_off       <= b_off;
                     axis_out_tdata <= b_data;
                     axis_out_tkeep <= b_keep;
                     axis_out_tlast <= (b_left == 16'd1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_packet_generator.sv
// Directed testbench for axis_packet_generator at DW=128, SEED_INIT=0.
// A packet table drives the main checks; reset behaviour and a mid-packet
// reset are exercised by hand-written sequences.

module tb_axis_packet_generator;

`ifdef PKT_GEN_LEN_HEADER_EN
   localparam bit HDR = 1'b1;
`else
   localparam bit HDR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [15:0]   axis_len_tdata = '0;
   logic          axis_len_tvalid = 1'b0;
   logic          axis_len_tready;
   logic [127:0]  axis_out_tdata;
   logic [15:0]   axis_out_tkeep;
   logic          axis_out_tlast;
   logic          axis_out_tvalid;
   logic          axis_out_tready = 1'b1;
   logic [31:0]   pkt_sent_count;

   int            checks = 0;
   int            errors = 0;
   logic [7:0]    m_seed = 8'h00;
   logic [31:0]   m_count = 32'd0;

   typedef struct {
      logic [15:0] len;
      int          beats;
      logic [15:0] last_keep;
      logic [7:0]  rdy_pat;
   } vec_t;

   vec_t vecs[8];

   axis_packet_generator #(.DW(128), .SEED_INIT(8'h00)) dut (
      .clk             (clk),
      .reset           (reset),
      .axis_len_tdata  (axis_len_tdata),
      .axis_len_tvalid (axis_len_tvalid),
      .axis_len_tready (axis_len_tready),
      .axis_out_tdata  (axis_out_tdata),
      .axis_out_tkeep  (axis_out_tkeep),
      .axis_out_tlast  (axis_out_tlast),
      .axis_out_tvalid (axis_out_tvalid),
      .axis_out_tready (axis_out_tready),
      .pkt_sent_count  (pkt_sent_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] exp_data(input logic [7:0] s, input int beat,
                                             input logic [15:0] len, input logic [15:0] keep);
      logic [7:0]   b;
      logic [127:0] d;
      d = '0;
      for (int k = 0; k < 16; k++) begin
         b = s + 8'(beat * 16 + k);
         if (HDR && beat == 0 && k == 0) b = len[7:0];
         if (HDR && beat == 0 && k == 1) b = len[15:8];
         if (keep[k]) d[8*k +: 8] = b;
      end
      return d;
   endfunction

   // Sends one descriptor and follows the packet to completion, stalling the
   // output according to rdy_pat (bit i = ready in cycle i mod 8).
   task automatic run_pkt(input logic [15:0] len, input int exp_beats,
                          input logic [15:0] last_keep, input logic [7:0] rdy_pat);
      int           beat;
      int           cyc;
      logic         rdy;
      logic         stalled;
      logic [127:0] hd;
      logic [15:0]  hk;
      logic         hl;
      logic [15:0]  ek;
      @(negedge clk);
      cyc = 0;
      while (!axis_len_tready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("len_tready_before_desc", {127'd0, axis_len_tready}, 128'd1);
      axis_len_tdata  = len;
      axis_len_tvalid = 1'b1;
      @(negedge clk);
      axis_len_tvalid = 1'b0;
      if (exp_beats == 0) begin
         check("zero_len_no_tvalid", {127'd0, axis_out_tvalid}, 128'd0);
         check("zero_len_tready", {127'd0, axis_len_tready}, 128'd1);
         check("zero_len_count", {96'd0, pkt_sent_count}, {96'd0, m_count});
         return;
      end
      check("first_beat_latency", {127'd0, axis_out_tvalid}, 128'd1);
      beat    = 0;
      cyc     = 0;
      stalled = 1'b0;
      hd      = '0;
      hk      = '0;
      hl      = 1'b0;
      while (beat < exp_beats && cyc < 200) begin
         if (!axis_out_tvalid) begin
            check("tvalid_mid_packet", {127'd0, axis_out_tvalid}, 128'd1);
            break;
         end
         ek = (beat == exp_beats - 1) ? last_keep : 16'hFFFF;
         check("beat_tdata", axis_out_tdata, exp_data(m_seed, beat, len, ek));
         check("beat_tkeep", {112'd0, axis_out_tkeep}, {112'd0, ek});
         check("beat_tlast", {127'd0, axis_out_tlast}, {127'd0, (beat == exp_beats - 1)});
         check("len_tready_in_send", {127'd0, axis_len_tready}, 128'd0);
         if (stalled) begin
            check("stall_hold_tdata", axis_out_tdata, hd);
            check("stall_hold_tkeep", {112'd0, axis_out_tkeep}, {112'd0, hk});
            check("stall_hold_tlast", {127'd0, axis_out_tlast}, {127'd0, hl});
         end
         rdy             = rdy_pat[cyc % 8];
         axis_out_tready = rdy;
         stalled         = !rdy;
         hd              = axis_out_tdata;
         hk              = axis_out_tkeep;
         hl              = axis_out_tlast;
         if (rdy) beat++;
         @(negedge clk);
         cyc++;
      end
      axis_out_tready = 1'b1;
      if (beat < exp_beats) begin
         errors++;
         $display("FAIL packet_timeout: got %0d beats expected %0d", beat, exp_beats);
      end
      m_seed  = m_seed + 8'd1;
      m_count = m_count + 32'd1;
      check("post_pkt_tvalid", {127'd0, axis_out_tvalid}, 128'd0);
      check("post_pkt_len_tready", {127'd0, axis_len_tready}, 128'd1);
      check("post_pkt_count", {96'd0, pkt_sent_count}, {96'd0, m_count});
   endtask

   initial begin
      vecs[0] = '{16'd16,  1,  16'hFFFF, 8'hFF};
      vecs[1] = '{16'd37,  3,  16'h001F, 8'hFF};
      vecs[2] = '{16'd0,   0,  16'h0000, 8'hFF};
      vecs[3] = '{16'd1,   1,  16'h0001, 8'hFF};
      vecs[4] = '{16'd48,  3,  16'hFFFF, 8'hE9};
      vecs[5] = '{16'd300, 19, 16'h0FFF, 8'hFF};
      vecs[6] = '{16'd17,  2,  16'h0001, 8'hB6};
      vecs[7] = '{16'd15,  1,  16'h7FFF, 8'h5A};

      // reset state
      repeat (2) @(negedge clk);
      check("rst_len_tready", {127'd0, axis_len_tready}, 128'd0);
      check("rst_tvalid", {127'd0, axis_out_tvalid}, 128'd0);
      check("rst_tlast", {127'd0, axis_out_tlast}, 128'd0);
      check("rst_tdata", axis_out_tdata, 128'd0);
      check("rst_tkeep", {112'd0, axis_out_tkeep}, 128'd0);
      check("rst_count", {96'd0, pkt_sent_count}, 128'd0);
      reset = 1'b0;
      @(negedge clk);
      check("release_len_tready", {127'd0, axis_len_tready}, 128'd1);

      for (int i = 0; i < 8; i++)
         run_pkt(vecs[i].len, vecs[i].beats, vecs[i].last_keep, vecs[i].rdy_pat);

      // reset while beat 2 of a len=64 packet is on the bus
      @(negedge clk);
      axis_len_tdata  = 16'd64;
      axis_len_tvalid = 1'b1;
      @(negedge clk);
      axis_len_tvalid = 1'b0;
      axis_out_tready = 1'b1;
      check("mid_rst_beat1_valid", {127'd0, axis_out_tvalid}, 128'd1);
      @(negedge clk);
      check("mid_rst_beat2_valid", {127'd0, axis_out_tvalid}, 128'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_tvalid", {127'd0, axis_out_tvalid}, 128'd0);
      check("mid_rst_tlast", {127'd0, axis_out_tlast}, 128'd0);
      check("mid_rst_count", {96'd0, pkt_sent_count}, 128'd0);
      check("mid_rst_len_tready", {127'd0, axis_len_tready}, 128'd0);
      @(negedge clk);
      reset   = 1'b0;
      m_seed  = 8'h00;
      m_count = 32'd0;
      run_pkt(16'd16, 1, 16'hFFFF, 8'hFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/axis_packet_generator.md
Name: axis_packet_generator

Overview:
- Transmit-side counterpart of the packet analyzer. Accepts 16-bit packet-length descriptors on an AXI-Stream and emits one AXI-Stream packet per descriptor, with a deterministic byte pattern and correct tkeep/tlast.
- Drives the analyzer's input stream in loopback and bring-up tests on the NEXYS A7.
- Single clock domain. All outputs are registered.

Parameters:
- DW, 128, output data width in bits; multiple of 8, range 16..512. BPB = DW/8 bytes per beat.
- SEED_INIT, 8'h00, reset value of the 8-bit per-packet pattern seed.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- axis_len_tdata  in  16  packet length in bytes.
- axis_len_tvalid  in  1  descriptor valid.
- axis_len_tready  out  1  descriptor accepted when high with tvalid.
- axis_out_tdata  out  DW  packet data; byte 0 = bits [7:0].
- axis_out_tkeep  out  DW/8  byte enables.
- axis_out_tlast  out  1  final beat of packet.
- axis_out_tvalid  out  1  beat valid.
- axis_out_tready  in  1  downstream ready.
- pkt_sent_count  out  32  number of packets whose tlast beat has handshaked; wraps at 2^32.

Behaviour:
- Reset: state=IDLE; axis_len_tready=0 during reset and 1 in the first cycle after release; axis_out_tvalid/tlast=0; tdata/tkeep=0; pkt_sent_count=0; seed=SEED_INIT.
- States: IDLE, SEND.
- IDLE: axis_len_tready=1, axis_out_tvalid=0.
  - Handshake with len=0: descriptor is consumed and dropped. No beats, no count increment, seed unchanged, remain IDLE.
  - Handshake with len>0: latch len, set beats_left=ceil(len/BPB), byte_off=0, go to SEND. The first beat is valid on the next cycle, so latency is 1 cycle.
- SEND: axis_len_tready=0 and axis_out_tvalid=1.
  - Beat contents: byte k of the beat (lane k) = (seed + byte_off + k) mod 256 when kept, 0 when not kept.
  - Non-final beats: tkeep all ones, tlast=0.
  - Final beat (beats_left==1): tlast=1. tkeep = low r bits set, where r = len mod BPB; r==0 gives all ones.
  - Stall (tvalid & !tready): tdata, tkeep and tlast are held stable. No state change.
  - Beat handshake: byte_off += BPB, beats_left -= 1.
  - Final-beat handshake: pkt_sent_count += 1, seed += 1 (mod 256), return to IDLE. axis_len_tready is high the following cycle, so the minimum inter-packet gap is 1 idle cycle on axis_out.
- byte_off width is 16 bits; the pattern uses only its low 8 bits. len=65535 is legal.
- Descriptor input is ignored while in SEND. The upstream FIFO holds pending descriptors.
- Reset asserted mid-packet: outputs clear asynchronously and the packet is truncated without tlast. The downstream consumer is reset in the same domain.

Optional Feature:
- Macro: PKT_GEN_LEN_HEADER_EN.
- Defined: the first beat carries the length in bytes 0..1, little-endian (lane0 = len[7:0], lane1 = len[15:8]). Both lanes obey tkeep, so a len=1 packet carries only len[7:0]. Pattern bytes from lane 2 onward are unchanged (seed + k).
- Undefined: the pure pattern is sent on every lane.

Test Plan:
- DW=128, seed=0, len=16 -> exactly 1 beat: tkeep=16'hFFFF, tlast=1, tdata bytes 00..0F; pkt_sent_count=1; axis_len_tready=1 the next cycle.
- len=37 -> 3 beats with tkeep FFFF, FFFF, 001F; tlast only on beat 3; beat 3 lanes 0..4 = 20..24, lanes 5..15 = 0; the following packet's bytes start at 01.
- len=0 descriptor followed by len=1 -> no output for len=0; the len=1 packet is 1 beat with tkeep=0001, lane0=00; seed and count unchanged by len=0.
- len=48 with axis_out_tready toggling 1,0,0,1,0,1 -> 3 beats delivered in order; tdata/tkeep/tlast held unchanged across every stall cycle.
- Reset pulse during beat 2 of a len=64 packet -> tvalid=0 and count=0 immediately; after release, len=16 produces bytes 00..0F (seed restored to SEED_INIT).
- With PKT_GEN_LEN_HEADER_EN defined, len=300 (0x012C) -> beat 0 lanes 0,1 = 2C,01 and lanes 2..15 = 02..0F; 19 beats; final tkeep=0FFF.
